aes_host_seq: RTL and testbench
===============================

// Module: aes_host_seq
// PURPOSE
//  Request sequencer directly upstream/downstream of aes_top. Accepts {key, plaintext} requests on a
//  valid/ready port and drives aes_top's opcode_i, start_i, key_i, r_con_i and plain_text_i.
//  Runs key generation when required, then encryption. Captures cipher_o and returns it on a
//  valid/ready output port. Adds a response timeout with a sticky error flag.
// PARAMETERS
//  OPC_W      2       width of opcode_o; matches aes_pkg::opcode
//  OPC_KEY    2'b01   opcode encoding for key generation
//  OPC_ENC    2'b10   opcode encoding for encryption
//  RCON_INIT  8'h01   constant driven on r_con_o
//  TO_CYC     64      max cycles spent in a wait state before timeout; must be >=2
// PORTS
//  clk            in   1     clock
//  nrst           in   1     asynchronous active-low reset
//  in_valid_i     in   1     request valid
//  in_ready_o     out  1     request accepted when in_valid_i && in_ready_o
//  in_new_key_i   in   1     force key generation with in_key_i
//  in_key_i       in   128   cipher key
//  in_pt_i        in   128   plaintext
//  out_valid_o    out  1     ciphertext valid
//  out_ready_i    in   1     ciphertext consumed when out_valid_o && out_ready_i
//  out_ct_o       out  128   ciphertext
//  err_timeout_o  out  1     sticky timeout flag
//  err_clr_i      in   1     clears err_timeout_o
//  key_loaded_o   out  1     round keys in the core are valid for key_o
//  opcode_o       out  OPC_W to aes_top opcode_i
//  start_o        out  1     to aes_top start_i; one-cycle pulse
//  key_o          out  128   to aes_top key_i; registered, stable outside IDLE
//  plain_text_o   out  128   to aes_top plain_text_i; registered, stable outside IDLE
//  r_con_o        out  8     to aes_top r_con_i; constant RCON_INIT
//  key_ready_i    in   1     from aes_top key_ready_o
//  cipher_ready_i in   1     from aes_top cipher_ready_o
//  busy_i         in   1     from aes_top busy_o
//  cipher_i       in   128   from aes_top cipher_o
// BEHAVIOUR
//  Reset: state=IDLE; all 1-bit outputs 0 (in_ready_o reflects IDLE && !out_valid_o, so it is 1);
//   out_ct_o, key_o, plain_text_o = 0; opcode_o = 0; timeout counter = 0.
//  FSM states: IDLE, KEY_GO, KEY_WAIT, ENC_GO, ENC_WAIT.
//  in_ready_o = (state==IDLE) && !out_valid_o && !busy_i. Combinational; no skid buffer.
//  Accept cycle T: register in_key_i into key_o and in_pt_i into plain_text_i.
//   If in_new_key_i || !key_loaded_o || in_key_i!=key_o, clear key_loaded_o and go to KEY_GO.
//   Otherwise go to ENC_GO.
//  KEY_GO: start_o=1 and opcode_o=OPC_KEY for exactly one cycle, then KEY_WAIT.
//  KEY_WAIT: on key_ready_i, set key_loaded_o and go to ENC_GO.
//  ENC_GO: start_o=1 and opcode_o=OPC_ENC for exactly one cycle, then ENC_WAIT.
//  ENC_WAIT: on cipher_ready_i, capture out_ct_o<=cipher_i, set out_valid_o, go to IDLE.
//  opcode_o holds its last value outside the GO states. start_o is never high in IDLE or WAIT states.
//  Latency: with a loaded key, start_o is seen at T+1. Key generation is adds wait time plus 1 cycle.
//  Output: out_valid_o stays high, and out_ct_o stays stable, until the handshake. Clear on handshake.
//   No new request is accepted while out_valid_o is high, so there is no overwrite.
//  Timeout: 8-bit-or-wider counter. Cleared on entering KEY_WAIT/ENC_WAIT; increments each cycle in
//   a wait state. When it reaches TO_CYC with no ready: set err_timeout_o, clear key_loaded_o, go to
//   IDLE, and do not assert out_valid_o.
//   A ready pulse arriving in the same cycle as expiry wins: the request completes normally, no error.
//  Stray ready pulses: key_ready_i or cipher_ready_i outside its matching WAIT state is ignored.
//  err_clr_i clears err_timeout_o. If it is asserted in the same cycle as a new timeout, set wins.
//  Async reset mid-operation returns to the reset values immediately. Any in-flight request is
//   dropped, and key_loaded_o=0.
// TESTING
//  1 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, with aes_top
//    -> exactly one KEY then one ENC start pulse; out_ct_o=69c4e0d86a7b0430d8cdb78070b4c55a.
//  2 Repeat the same key with in_new_key_i=0 -> no KEY pulse; start_o at T+1; correct ciphertext.
//  3 Hold out_ready_i=0 for 20 cycles after out_valid_o -> in_ready_o=0 throughout; out_ct_o stable.
//  4 Core model never raises key_ready_i, TO_CYC=64 -> err_timeout_o set 64 cycles after entering
//    KEY_WAIT; state IDLE; key_loaded_o=0; err_clr_i clears the flag.
//  5 Pulse nrst during ENC_WAIT -> all outputs at reset values; next request regenerates the key.
//  6 cipher_ready_i pulsed while in KEY_WAIT -> ignored; the flow completes with the correct result.

Source files
------------

// File: rtl/aes_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_host_seq : request sequencer for aes_top (key generation, encryption,
//                response capture, response timeout)            rev 1.0
// ----------------------------------------------------------------------------
module aes_host_seq #(
  parameter int               OPC_W     = 2,
  parameter logic [OPC_W-1:0] OPC_KEY   = 2'b01,
  parameter logic [OPC_W-1:0] OPC_ENC   = 2'b10,
  parameter logic [7:0]       RCON_INIT = 8'h01,
  parameter int               TO_CYC    = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_new_key_i,
  input  logic [127:0]     in_key_i,
  input  logic [127:0]     in_pt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_ct_o,
  output logic             err_timeout_o,
  input  logic             err_clr_i,
  output logic             key_loaded_o,
  output logic [OPC_W-1:0] opcode_o,
  output logic             start_o,
  output logic [127:0]     key_o,
  output logic [127:0]     plain_text_o,
  output logic [7:0]       r_con_o,
  input  logic             key_ready_i,
  input  logic             cipher_ready_i,
  input  logic             busy_i,
  input  logic [127:0]     cipher_i
);

  localparam int CNT_W = ($clog2(TO_CYC + 1) < 8) ? 8 : $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_GO   = 3'd1,
    S_KEY_WAIT = 3'd2,
    S_ENC_GO   = 3'd3,
    S_ENC_WAIT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       ct_q, ct_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic               start_q, start_d;
  logic               key_loaded_q, key_loaded_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready;

  assign in_ready = (state_q == S_IDLE) && !out_valid_q && !busy_i;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    opcode_d     = opcode_q;
    start_d      = 1'b0;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    if (err_clr_i) err_d = 1'b0;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    // start_q/opcode_q are loaded on the edge entering a GO state so the
    // pulse lines up exactly with that state.
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready) begin
          key_d   = in_key_i;
          pt_d    = in_pt_i;
          start_d = 1'b1;
          if (in_new_key_i || !key_loaded_q || (in_key_i != key_q)) begin
            key_loaded_d = 1'b0;
            opcode_d     = OPC_KEY;
            state_d      = S_KEY_GO;
          end else begin
            opcode_d = OPC_ENC;
            state_d  = S_ENC_GO;
          end
        end
      end
      S_KEY_GO: begin
        cnt_d   = '0;
        state_d = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        // a ready arriving on the expiry cycle takes priority over the timeout
        if (key_ready_i) begin
          key_loaded_d = 1'b1;
          opcode_d     = OPC_ENC;
          start_d      = 1'b1;
          state_d      = S_ENC_GO;
        end else if (cnt_q == CNT_LAST) begin
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ENC_GO: begin
        cnt_d   = '0;
        state_d = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        if (cipher_ready_i) begin
          ct_d        = cipher_i;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d        = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      opcode_q     <= '0;
      start_q      <= 1'b0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      opcode_q     <= opcode_d;
      start_q      <= start_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o    = in_ready;
  assign out_valid_o   = out_valid_q;
  assign out_ct_o      = ct_q;
  assign err_timeout_o = err_q;
  assign key_loaded_o  = key_loaded_q;
  assign opcode_o      = opcode_q;
  assign start_o       = start_q;
  assign key_o         = key_q;
  assign plain_text_o  = pt_q;
  assign r_con_o       = RCON_INIT;

endmodule
`default_nettype wire

// File: tb/tb_aes_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_host_seq : aes_host_seq against a behavioural AES core and a
//                   request-level reference model                 rev 1.0
// ----------------------------------------------------------------------------
module tb_aes_host_seq;

  localparam logic [1:0] OPC_KEY = 2'b01;
  localparam logic [1:0] OPC_ENC = 2'b10;
  localparam int         TO_CYC  = 64;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid_i = 1'b0, in_ready_o, in_new_key_i = 1'b0;
  logic [127:0] in_key_i = '0, in_pt_i = '0;
  logic         out_valid_o, out_ready_i = 1'b0;
  logic [127:0] out_ct_o;
  logic         err_timeout_o, err_clr_i = 1'b0, key_loaded_o;
  logic [1:0]   opcode_o;
  logic         start_o;
  logic [127:0] key_o, plain_text_o;
  logic [7:0]   r_con_o;
  logic         key_ready_i, cipher_ready_i, busy_i;
  logic [127:0] cipher_i;

  always #5 clk = ~clk;

  aes_host_seq #(
    .OPC_W(2), .OPC_KEY(OPC_KEY), .OPC_ENC(OPC_ENC), .RCON_INIT(8'h01), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_new_key_i(in_new_key_i),
    .in_key_i(in_key_i), .in_pt_i(in_pt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ct_o(out_ct_o),
    .err_timeout_o(err_timeout_o), .err_clr_i(err_clr_i), .key_loaded_o(key_loaded_o),
    .opcode_o(opcode_o), .start_o(start_o), .key_o(key_o), .plain_text_o(plain_text_o),
    .r_con_o(r_con_o), .key_ready_i(key_ready_i), .cipher_ready_i(cipher_ready_i),
    .busy_i(busy_i), .cipher_i(cipher_i)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rk [16];
    logic [7:0] w [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      s[i]  = pt[127-8*i -: 8] ^ rk[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w[0] = sbox[rk[13]] ^ rc;
      w[1] = sbox[rk[14]];
      w[2] = sbox[rk[15]];
      w[3] = sbox[rk[12]];
      for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ w[i];
      for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- behavioural aes_top ----------------
  int           key_dly = 4, enc_dly = 6;
  bit           mute_key = 1'b0;
  logic         stray_cr = 1'b0;
  logic         core_active, kr_m, cr_m;
  logic [1:0]   core_op;
  int           core_cnt;
  logic [127:0] core_key, core_pt, core_ct;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_active <= 1'b0; kr_m <= 1'b0; cr_m <= 1'b0; core_op <= 2'b00; core_cnt <= 0;
      core_key <= '0; core_pt <= '0; core_ct <= '0;
    end else begin
      kr_m <= 1'b0;
      cr_m <= 1'b0;
      if (core_active) begin
        if (core_cnt <= 1) begin
          core_active <= 1'b0;
          if (core_op == OPC_KEY) begin
            if (!mute_key) kr_m <= 1'b1;
          end else begin
            core_ct <= aes_enc(core_key, core_pt);
            cr_m    <= 1'b1;
          end
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end else if (start_o) begin
        core_active <= 1'b1;
        core_op     <= opcode_o;
        core_cnt    <= (opcode_o == OPC_KEY) ? key_dly : enc_dly;
        if (opcode_o == OPC_KEY) core_key <= key_o;
        else core_pt <= plain_text_o;
      end
    end
  end

  assign key_ready_i    = kr_m;
  assign cipher_ready_i = cr_m | stray_cr;
  assign busy_i         = core_active;
  assign cipher_i       = core_ct;

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // request-level model: whether the core holds round keys, and for which key
  bit           m_loaded = 1'b0;
  logic [127:0] m_key = '0;

  task automatic run_req(input logic [127:0] k, input logic [127:0] p, input logic nk,
                         input int hold, input bit stray, input bit exp_to,
                         input logic [127:0] ct_exp);
    bit need, done;
    int cyc, key_cyc, enc_cyc, nkey, nenc, err_cyc;
    need = nk || !m_loaded || (k != m_key);
    @(negedge clk);
    in_valid_i = 1'b1; in_key_i = k; in_pt_i = p; in_new_key_i = nk;
    cyc = 0;
    #1;
    while (!in_ready_o && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    chk("accept_ready", 128'(in_ready_o), 128'd1);
    @(posedge clk);
    m_key = k;
    if (need) m_loaded = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b0; in_new_key_i = 1'b0;
    chk("key_o", key_o, k);
    chk("plain_text_o", plain_text_o, p);
    nkey = 0; nenc = 0; key_cyc = 0; enc_cyc = 0; err_cyc = 0; done = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      stray_cr = stray && (nkey == 1) && (c == key_cyc + 3);
      if (start_o) begin
        if (opcode_o == OPC_KEY) begin nkey++; if (key_cyc == 0) key_cyc = c; end
        else if (opcode_o == OPC_ENC) begin nenc++; if (enc_cyc == 0) enc_cyc = c; end
      end
      if (out_valid_o) done = 1'b1;
      else if (err_timeout_o) begin done = 1'b1; err_cyc = c; end
      else @(negedge clk);
    end
    stray_cr = 1'b0;
    chk("req_done", 128'(done), 128'd1);
    chk("key_pulses", 128'(nkey), need ? 128'd1 : 128'd0);
    chk("first_start_cyc", 128'(need ? key_cyc : enc_cyc), 128'd1);
    if (exp_to) begin
      chk("enc_pulses", 128'(nenc), 128'd0);
      chk("timeout_cyc", 128'(err_cyc), 128'(key_cyc + TO_CYC + 1));
      chk("timeout_err", 128'(err_timeout_o), 128'd1);
      chk("timeout_no_valid", 128'(out_valid_o), 128'd0);
      chk("timeout_key_loaded", 128'(key_loaded_o), 128'd0);
      chk("timeout_idle_ready", 128'(in_ready_o), 128'd1);
      m_loaded = 1'b0;
    end else begin
      chk("enc_pulses", 128'(nenc), 128'd1);
      chk("ciphertext", out_ct_o, ct_exp);
      chk("key_loaded", 128'(key_loaded_o), 128'd1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_in_ready", 128'(in_ready_o), 128'd0);
        chk("hold_ct", out_ct_o, ct_exp);
        chk("hold_valid", 128'(out_valid_o), 128'd1);
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("valid_cleared", 128'(out_valid_o), 128'd0);
      m_loaded = 1'b1;
    end
  endtask

  initial begin
    logic [7:0]   inv;
    logic [127:0] k, p;
    int           cyc;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_out_ct", out_ct_o, 128'd0);
    chk("rst_key_o", key_o, 128'd0);
    chk("rst_pt_o", plain_text_o, 128'd0);
    chk("rst_opcode", 128'(opcode_o), 128'd0);
    chk("rst_start", 128'(start_o), 128'd0);
    chk("rst_err", 128'(err_timeout_o), 128'd0);
    chk("rst_key_loaded", 128'(key_loaded_o), 128'd0);
    chk("r_con", 128'(r_con_o), 128'h01);
    @(negedge clk);
    nrst = 1'b1;

    // known-answer flow, then key reuse, then back-pressure
    run_req(K1, P1, 1'b0, 0, 1'b0, 1'b0, C1);
    run_req(K1, P1, 1'b0, 0, 1'b0, 1'b0, C1);
    run_req(K1, P1, 1'b0, 20, 1'b0, 1'b0, C1);

    // stray cipher_ready during key generation
    key_dly = 10;
    p = {$urandom, $urandom, $urandom, $urandom};
    run_req(K1, p, 1'b1, 1, 1'b1, 1'b0, aes_enc(K1, p));

    // key generation never answers
    mute_key = 1'b1; key_dly = 5;
    run_req(K1, P1, 1'b1, 0, 1'b0, 1'b1, '0);
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    chk("err_cleared", 128'(err_timeout_o), 128'd0);

    // key_ready on the exact expiry cycle completes normally
    mute_key = 1'b0; key_dly = TO_CYC - 1;
    run_req(K1, P1, 1'b1, 0, 1'b0, 1'b0, C1);
    chk("expiry_ready_no_err", 128'(err_timeout_o), 128'd0);

    // one cycle too late: timeout, with err_clr held high (set wins, then clears)
    key_dly = TO_CYC; err_clr_i = 1'b1;
    run_req(K1, P1, 1'b1, 0, 1'b0, 1'b1, '0);
    @(negedge clk);
    chk("clr_after_set", 128'(err_timeout_o), 128'd0);
    chk("late_ready_ignored", 128'(key_loaded_o), 128'd0);
    err_clr_i = 1'b0;

    // reset in the middle of ENC_WAIT
    key_dly = 4; enc_dly = 20;
    run_req(K1, P1, 1'b0, 0, 1'b0, 1'b0, C1);
    @(negedge clk);
    in_valid_i = 1'b1; in_key_i = K1; in_pt_i = 128'h5a5a; in_new_key_i = 1'b0;
    cyc = 0;
    #1;
    while (!in_ready_o && cyc < 50) begin @(negedge clk); #1; cyc++; end
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("pre_rst_enc_start", 128'({start_o, opcode_o}), 128'({1'b1, OPC_ENC}));
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("mid_rst_key_o", key_o, 128'd0);
    chk("mid_rst_opcode", 128'(opcode_o), 128'd0);
    chk("mid_rst_key_loaded", 128'(key_loaded_o), 128'd0);
    chk("mid_rst_valid", 128'(out_valid_o), 128'd0);
    @(negedge clk);
    nrst = 1'b1;
    m_loaded = 1'b0; m_key = '0;
    enc_dly = 6;
    run_req(K1, P1, 1'b0, 0, 1'b0, 1'b0, C1);

    // randomized requests
    for (int i = 0; i < 12; i++) begin
      k = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom, $urandom, $urandom} : m_key;
      p = {$urandom, $urandom, $urandom, $urandom};
      key_dly = $urandom_range(1, 20);
      enc_dly = $urandom_range(1, 20);
      run_req(k, p, ($urandom_range(0, 3) == 0), $urandom_range(0, 4), 1'b0, 1'b0,
              aes_enc(k, p));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
